// File: rtl/p1bomb_pkg.sv
// Shared types and constants for the player-1 bomb fuse controller.
package p1bomb_pkg;

  localparam int TILE_W     = 7;
  localparam int GRID_TILES = 121;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUSE  = 2'd1,
    BLAST = 2'd2
  } bomb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/p1bomb_slot.sv
// One bomb slot: owns its IDLE/FUSE/BLAST state, countdown and latched tile.
module p1bomb_slot
  import p1bomb_pkg::*;
#(
  parameter int FUSE_CYCLES  = 150_000_000,
  parameter int BLAST_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TILE_W-1:0] tile_in,
  output logic              active,
  output logic              blast,
  output logic [TILE_W-1:0] tile,
  output logic              blast_start
);

  localparam int CNT_W = $clog2(max_int(FUSE_CYCLES, BLAST_CYCLES));

  bomb_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic              blast_start_q, blast_start_d;

  // NOTE: every next-state signal gets a default first so no path through the
  // case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tile_d        = tile_q;
    blast_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = FUSE;
          cnt_d   = CNT_W'(FUSE_CYCLES - 1);
          tile_d  = tile_in;
        end
      end
      FUSE: begin
        if (cnt_q == '0) begin
          state_d       = BLAST;
          cnt_d         = CNT_W'(BLAST_CYCLES - 1);
          blast_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BLAST: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tile_q        <= '0;
      blast_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tile_q        <= tile_d;
      blast_start_q <= blast_start_d;
    end
  end

  assign active      = (state_q != IDLE);
  assign blast       = (state_q == BLAST);
  assign tile        = tile_q;
  assign blast_start = blast_start_q;

endmodule

// File: rtl/p1bomb_fuse_ctrl.sv
// Player-1 bomb fuse controller: request edge detect, slot allocation and
// duplicate-tile rejection in front of MAX_BOMBS independent bomb slots.
module p1bomb_fuse_ctrl
  import p1bomb_pkg::*;
#(
  parameter int MAX_BOMBS    = 2,
  parameter int FUSE_CYCLES  = 150_000_000,
  parameter int BLAST_CYCLES = 25_000_000,
  parameter int GRID_TILES   = p1bomb_pkg::GRID_TILES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  cmd,
  output logic [MAX_BOMBS-1:0]        slot_active,
  output logic [MAX_BOMBS-1:0]        slot_blast,
  output logic [TILE_W*MAX_BOMBS-1:0] slot_tile,
  output logic [MAX_BOMBS-1:0]        blast_start,
  output logic                        place_ack,
  output logic                        place_drop
);

  localparam logic [TILE_W:0] TILE_LIMIT = (TILE_W + 1)'(GRID_TILES);

  logic              req_q;
  logic              ack_q, ack_d;
  logic              drop_q, drop_d;
  logic              req;
  logic [TILE_W-1:0] req_tile;
  logic              dup;
  logic              found;
  logic [MAX_BOMBS-1:0] first_free;
  logic [MAX_BOMBS-1:0] load;

  assign req      = cmd[7] & ~req_q;
  assign req_tile = cmd[TILE_W-1:0];

  // A slot leaving BLAST this cycle still reads active, so it is neither free
  // nor excluded from the duplicate check until the following cycle.
  always_comb begin
    dup        = 1'b0;
    found      = 1'b0;
    first_free = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_active[i] && (slot_tile[TILE_W*i +: TILE_W] == req_tile)) dup = 1'b1;
      if (!found && !slot_active[i]) begin
        first_free[i] = 1'b1;
        found         = 1'b1;
      end
    end
    ack_d  = req && found && !dup && ({1'b0, req_tile} < TILE_LIMIT);
    drop_d = req && !ack_d;
  end

  assign load = ack_d ? first_free : '0;

  // req_q resets high so a place bit held across reset needs a fresh 0->1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b1;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      req_q  <= cmd[7];
      ack_q  <= ack_d;
      drop_q <= drop_d;
    end
  end

  assign place_ack  = ack_q;
  assign place_drop = drop_q;

  for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
    p1bomb_slot #(
      .FUSE_CYCLES (FUSE_CYCLES),
      .BLAST_CYCLES(BLAST_CYCLES)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (load[g]),
      .tile_in    (req_tile),
      .active     (slot_active[g]),
      .blast      (slot_blast[g]),
      .tile       (slot_tile[TILE_W*g +: TILE_W]),
      .blast_start(blast_start[g])
    );
  end

endmodule
